// File: rtl/aclock_pkg.sv
// Shared types and BCD time helpers for the multi-alarm clock.
// Times are carried as packed BCD digit structs so they compare and concatenate directly.
package aclock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } hhmm_t;

    typedef struct packed {
        hhmm_t      hm;
        logic [3:0] s1;
        logic [3:0] s0;
    } hhmmss_t;

    localparam int      MINS_PER_DAY = 1440;
    localparam hhmmss_t TIME_MAX     = {2'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9};

    function automatic logic bcd_valid_hhmm(input hhmm_t t);
        return (t.h0 <= 4'd9) && (t.m1 <= 4'd5) && (t.m0 <= 4'd9) &&
               ((t.h1 < 2'd2) || ((t.h1 == 2'd2) && (t.h0 <= 4'd3)));
    endfunction

    // Only ever called with a constant minute offset, so the divides fold to constant-divisor logic.
    function automatic hhmm_t hhmm_add_min(input hhmm_t t, input int mins);
        int    total;
        int    hh;
        int    mm;
        hhmm_t r;
        total = ((int'(t.h1) * 10 + int'(t.h0)) * 60 + int'(t.m1) * 10 + int'(t.m0) + mins)
                % MINS_PER_DAY;
        hh   = total / 60;
        mm   = total % 60;
        r.h1 = 2'(hh / 10);
        r.h0 = 4'(hh % 10);
        r.m1 = 4'(mm / 10);
        r.m0 = 4'(mm % 10);
        return r;
    endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// Tick prescaler plus 24-hour BCD H:M:S counter with a synchronous load of H:M.
// step_o marks the cycles where time_nxt_o becomes the new time.
module bcd_time_counter
    import aclock_pkg::*;
#(
    parameter int CLK_DIV = 1
)(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    ld_i,
    input  hhmm_t   ld_val_i,
    output hhmmss_t time_o,
    output hhmmss_t time_nxt_o,
    output logic    step_o
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0] pre_q, pre_d;
    hhmmss_t       time_q, time_d, time_inc;
    logic          tick;

    assign tick = (pre_q == PW'(CLK_DIV - 1));

    always_comb begin
        time_inc = time_q;
        if (time_q == TIME_MAX) begin
            time_inc = '0;
        end else if (time_q.s0 != 4'd9) begin
            time_inc.s0 = time_q.s0 + 4'd1;
        end else begin
            time_inc.s0 = '0;
            if (time_q.s1 != 4'd5) begin
                time_inc.s1 = time_q.s1 + 4'd1;
            end else begin
                time_inc.s1 = '0;
                if (time_q.hm.m0 != 4'd9) begin
                    time_inc.hm.m0 = time_q.hm.m0 + 4'd1;
                end else begin
                    time_inc.hm.m0 = '0;
                    if (time_q.hm.m1 != 4'd5) begin
                        time_inc.hm.m1 = time_q.hm.m1 + 4'd1;
                    end else begin
                        time_inc.hm.m1 = '0;
                        if (time_q.hm.h0 != 4'd9) begin
                            time_inc.hm.h0 = time_q.hm.h0 + 4'd1;
                        end else begin
                            time_inc.hm.h0 = '0;
                            time_inc.hm.h1 = time_q.hm.h1 + 2'd1;
                        end
                    end
                end
            end
        end
    end

    // A load wins over a coincident tick and restarts the second from scratch.
    always_comb begin
        pre_d  = tick ? '0 : pre_q + PW'(1);
        time_d = tick ? time_inc : time_q;
        if (ld_i) begin
            pre_d  = '0;
            time_d = {ld_val_i, 8'h00};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            time_q <= '0;
        end else begin
            pre_q  <= pre_d;
            time_q <= time_d;
        end
    end

    assign time_o     = time_q;
    assign time_nxt_o = time_inc;
    assign step_o     = tick & ~ld_i;

endmodule

// File: rtl/multi_alarm_clock.sv
// 24-hour BCD clock with NUM_ALARMS alarm slots, snooze and ring timeout.
// Alarm matching looks at the time about to be registered, so Alarm rises together with HH:MM:00.
module multi_alarm_clock
    import aclock_pkg::*;
#(
    parameter int  CLK_DIV      = 1,
    parameter int  NUM_ALARMS   = 4,
    parameter int  SNOOZE_MIN   = 5,
    parameter int  RING_TIMEOUT = 60,
    localparam int AW           = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            H_in1,
    input  logic [3:0]            H_in0,
    input  logic [3:0]            M_in1,
    input  logic [3:0]            M_in0,
    input  logic                  LD_time,
    input  logic                  LD_alarm,
    input  logic [AW-1:0]         AL_SEL,
    input  logic [NUM_ALARMS-1:0] AL_EN,
    input  logic                  STOP_al,
    input  logic                  SNOOZE,
    output logic                  Alarm,
    output logic [AW-1:0]         AL_ID,
    output logic [1:0]            H_out1,
    output logic [3:0]            H_out0,
    output logic [3:0]            M_out1,
    output logic [3:0]            M_out0,
    output logic [3:0]            S_out1,
    output logic [3:0]            S_out0
);
    hhmm_t                 ld_val;
    logic                  ld_ok, ld_time_ok, ld_alarm_ok;
    hhmmss_t               time_q, time_nxt;
    logic                  step;
    hhmm_t                 alarm_q [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] hit;
    logic                  any_hit, tgt_hit, en_cur, snooze_rise;
    logic [AW-1:0]         hit_id;
    state_e                state_q, state_d;
    logic [AW-1:0]         al_id_q, al_id_d;
    logic [7:0]            ring_q, ring_d;
    hhmm_t                 target_q, target_d;
    logic                  snooze_q;

    assign ld_val      = {H_in1, H_in0, M_in1, M_in0};
    assign ld_ok       = bcd_valid_hhmm(ld_val);
    assign ld_time_ok  = LD_time & ld_ok;
    assign ld_alarm_ok = LD_alarm & ld_ok & (32'(AL_SEL) < NUM_ALARMS);

    bcd_time_counter #(.CLK_DIV(CLK_DIV)) u_time (
        .clk        (clk),
        .rst_n      (reset),
        .ld_i       (ld_time_ok),
        .ld_val_i   (ld_val),
        .time_o     (time_q),
        .time_nxt_o (time_nxt),
        .step_o     (step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) alarm_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++)
                if (ld_alarm_ok && (AL_SEL == AW'(i))) alarm_q[i] <= ld_val;
        end
    end

    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_hit
        assign hit[gi] = step && AL_EN[gi] && (time_nxt == {alarm_q[gi], 8'h00});
    end

    // Scan downwards so the lowest matching slot is the one left standing.
    always_comb begin
        any_hit = 1'b0;
        hit_id  = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                any_hit = 1'b1;
                hit_id  = AW'(i);
            end
        end
    end

    assign en_cur      = AL_EN[al_id_q];
    assign tgt_hit     = step && (time_nxt == {target_q, 8'h00});
    assign snooze_rise = SNOOZE & ~snooze_q;

    always_comb begin
        state_d  = state_q;
        al_id_d  = al_id_q;
        ring_d   = ring_q;
        target_d = target_q;
        if (ld_time_ok) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_hit && !STOP_al) begin
                        state_d = RINGING;
                        al_id_d = hit_id;
                        ring_d  = '0;
                    end
                end
                RINGING: begin
                    if (STOP_al || !en_cur) begin
                        state_d = IDLE;
                    end else if (snooze_rise) begin
                        state_d  = SNOOZED;
                        target_d = hhmm_add_min(time_q.hm, SNOOZE_MIN);
                    end else if (step) begin
                        ring_d = ring_q + 8'd1;
                        if (ring_q == 8'(RING_TIMEOUT - 1)) state_d = IDLE;
                    end
                end
                SNOOZED: begin
                    if (STOP_al || !en_cur) begin
                        state_d = IDLE;
                    end else if (any_hit) begin
                        state_d = RINGING;
                        al_id_d = hit_id;
                        ring_d  = '0;
                    end else if (tgt_hit) begin
                        state_d = RINGING;
                        ring_d  = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            al_id_q  <= '0;
            ring_q   <= '0;
            target_q <= '0;
            snooze_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            al_id_q  <= al_id_d;
            ring_q   <= ring_d;
            target_q <= target_d;
            snooze_q <= SNOOZE;
        end
    end

    assign {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0} = time_q;
    assign Alarm = (state_q == RINGING);
    assign AL_ID = al_id_q;

endmodule
